shift_unit_seq: RTL and testbench

//  Parametrised iterative shifter for the MIPS datapath (SLL/SRL/SRA/ROL, variable amount).

---
 rtl/shift_unit_seq.sv | 140 ++++++++++++++
 tb/tb_shift_unit_seq.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_unit_seq.sv
// Iterative shifter (SLL/SRL/SRA/ROL) moving up to STEP bit positions per clock,
// with valid/ready handshakes on the request and result sides.
module shift_unit_seq #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = $clog2(WIDTH),
    parameter int unsigned STEP    = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [WIDTH-1:0]   i_data,
    input  logic [SHAMT_W-1:0] i_shamt,
    input  logic [1:0]         i_mode,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [WIDTH-1:0]   o_data,
    output logic               o_busy
);

    localparam logic [SHAMT_W-1:0] STEP_AMT  = SHAMT_W'(STEP);
    localparam logic [SHAMT_W:0]   WIDTH_AMT = (SHAMT_W+1)'(WIDTH);

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRL = 2'b01;
    localparam logic [1:0] MODE_SRA = 2'b10;
    localparam logic [1:0] MODE_ROL = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               ready_q, ready_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [SHAMT_W-1:0] rem_q, rem_d;
    logic [1:0]         mode_q, mode_d;

    logic [SHAMT_W-1:0] step_k;
    logic [SHAMT_W:0]   rot_back;
    logic [WIDTH-1:0]   shifted;

    // One partial shift of the working register by min(STEP, remaining)
    always_comb begin
        step_k   = (rem_q > STEP_AMT) ? STEP_AMT : rem_q;
        rot_back = WIDTH_AMT - {1'b0, step_k};
        shifted  = work_q;
        case (mode_q)
            MODE_SLL: shifted = work_q << step_k;
            MODE_SRL: shifted = work_q >> step_k;
            MODE_SRA: shifted = $signed(work_q) >>> step_k;
            MODE_ROL: shifted = (work_q << step_k) | (work_q >> rot_back);
            default:  shifted = work_q;
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        ready_d = ready_q;
        valid_d = valid_q;
        data_d  = data_q;
        work_d  = work_q;
        rem_d   = rem_q;
        mode_d  = mode_q;
        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (i_valid && ready_q) begin
                    ready_d = 1'b0;
                    work_d  = i_data;
                    mode_d  = i_mode;
                    rem_d   = i_shamt;
                    if (i_shamt == '0) begin
                        data_d  = i_data;
                        valid_d = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                work_d = shifted;
                rem_d  = rem_q - step_k;
                if (rem_q == step_k) begin
                    data_d  = shifted;
                    valid_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (i_ready) begin
                    valid_d = 1'b0;
                    ready_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                ready_d = 1'b0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            data_q  <= '0;
            work_q  <= '0;
            rem_q   <= '0;
            mode_q  <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            data_q  <= data_d;
            work_q  <= work_d;
            rem_q   <= rem_d;
            mode_q  <= mode_d;
        end
    end

    assign o_ready = ready_q;
    assign o_valid = valid_q;
    assign o_busy  = busy_q;
    assign o_data  = data_q;

endmodule

// File: tb/tb_shift_unit_seq.sv
// Bench for shift_unit_seq: directed vector table, backpressure and reset corners,
// then randomised operations against a single-shot reference model.
module tb_shift_unit_seq;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned SHAMT_W = 5;
    localparam int unsigned STEP    = 4;

    logic               i_clk;
    logic               i_rst_n;
    logic               i_valid;
    logic               o_ready;
    logic [WIDTH-1:0]   i_data;
    logic [SHAMT_W-1:0] i_shamt;
    logic [1:0]         i_mode;
    logic               o_valid;
    logic               i_ready;
    logic [WIDTH-1:0]   o_data;
    logic               o_busy;

    shift_unit_seq #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W), .STEP(STEP)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (i_data),
        .i_shamt (i_shamt),
        .i_mode  (i_mode),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_busy  (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  shamt;
        logic [1:0]  mode;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t        vecs[11];
    int          passed = 0;
    int          total  = 0;
    logic [31:0] prev_result = 32'h0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // Single-shot reference: whole shift applied at once on widened operands
    function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] s,
                                              input logic [1:0] m);
        logic [63:0] w;
        case (m)
            2'b00: begin w = {32'h0, d} << s;           return w[31:0];  end
            2'b01: begin w = {32'h0, d} >> s;           return w[31:0];  end
            2'b10: begin w = {{32{d[31]}}, d} >> s;     return w[31:0];  end
            default: begin w = {d, d} << s;             return w[63:32]; end
        endcase
    endfunction

    function automatic int ref_lat(input logic [4:0] s);
        return (int'(s) + int'(STEP) - 1) / int'(STEP);
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Issue one request, check latency, hold-off behaviour and release
    task automatic do_op(input logic [31:0] d, input logic [4:0] s, input logic [1:0] m,
                         input logic [31:0] exp, input int exp_lat, input int hold,
                         input string name);
        int n;
        int lat;
        n = 0;
        while (o_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            chk({name, "_ready_timeout"}, 32'(o_ready), 32'h1);
            return;
        end
        i_valid = 1'b1;
        i_data  = d;
        i_shamt = s;
        i_mode  = m;
        tick();
        i_valid = 1'b0;
        i_data  = $urandom;
        i_shamt = 5'($urandom);
        i_mode  = 2'($urandom);
        chk({name, "_ready_drop"}, 32'(o_ready), 32'h0);
        lat = 0;
        while (o_valid !== 1'b1 && lat < 40) begin
            chk({name, "_hold_prev"}, o_data, prev_result);
            i_ready = 1'($urandom);
            tick();
            lat++;
        end
        i_ready = 1'b0;
        chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({name, "_data"}, o_data, exp);
        chk({name, "_busy"}, 32'(o_busy), 32'h1);
        for (int i = 0; i < hold; i++) begin
            i_valid = 1'b1;
            i_data  = $urandom;
            i_shamt = 5'($urandom_range(1, 31));
            tick();
            chk({name, "_bp_valid"}, 32'(o_valid), 32'h1);
            chk({name, "_bp_data"}, o_data, exp);
            chk({name, "_bp_ready"}, 32'(o_ready), 32'h0);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        chk({name, "_rel_valid"}, 32'(o_valid), 32'h0);
        chk({name, "_rel_ready"}, 32'(o_ready), 32'h1);
        chk({name, "_rel_busy"}, 32'(o_busy), 32'h0);
        chk({name, "_rel_data"}, o_data, exp);
        prev_result = exp;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{32'hFFFF_FFFF, 5'd2,  2'b00, 32'hFFFF_FFFC, 1};
        vecs[1]  = '{32'h8000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF, 8};
        vecs[2]  = '{32'h8000_0000, 5'd31, 2'b01, 32'h0000_0001, 8};
        vecs[3]  = '{32'h8000_0001, 5'd4,  2'b11, 32'h0000_0018, 1};
        vecs[4]  = '{32'h1234_5678, 5'd0,  2'b00, 32'h1234_5678, 0};
        vecs[5]  = '{32'h1234_5678, 5'd0,  2'b01, 32'h1234_5678, 0};
        vecs[6]  = '{32'h1234_5678, 5'd0,  2'b10, 32'h1234_5678, 0};
        vecs[7]  = '{32'h1234_5678, 5'd0,  2'b11, 32'h1234_5678, 0};
        vecs[8]  = '{32'h0000_0001, 5'd5,  2'b00, 32'h0000_0020, 2};
        vecs[9]  = '{32'hF000_0000, 5'd31, 2'b11, 32'h7800_0000, 8};
        vecs[10] = '{32'h7FFF_FFFF, 5'd3,  2'b10, 32'h0FFF_FFFF, 1};

        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_data  = '0;
        i_shamt = '0;
        i_mode  = '0;
        #12;
        chk("rst_ready", 32'(o_ready), 32'h0);
        chk("rst_valid", 32'(o_valid), 32'h0);
        chk("rst_data", o_data, 32'h0);
        chk("rst_busy", 32'(o_busy), 32'h0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        #1;
        chk("rel_ready_low", 32'(o_ready), 32'h0);
        tick();
        chk("rel_ready_high", 32'(o_ready), 32'h1);

        foreach (vecs[i])
            do_op(vecs[i].data, vecs[i].shamt, vecs[i].mode, vecs[i].exp, vecs[i].lat,
                  0, $sformatf("vec%0d", i));

        do_op(32'hFFFF_FFFF, 5'd2, 2'b00, 32'hFFFF_FFFC, 1, 5, "backpressure");
        do_op(32'hCAFE_F00D, 5'd0, 2'b10, 32'hCAFE_F00D, 0, 3, "bp_zero");

        // Reset in the middle of a long shift discards the operation
        i_valid = 1'b1;
        i_data  = 32'h8000_0000;
        i_shamt = 5'd31;
        i_mode  = 2'b10;
        tick();
        i_valid = 1'b0;
        tick();
        tick();
        i_rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(o_valid), 32'h0);
        chk("midrst_data", o_data, 32'h0);
        chk("midrst_ready", 32'(o_ready), 32'h0);
        chk("midrst_busy", 32'(o_busy), 32'h0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        tick();
        chk("midrst_ready_back", 32'(o_ready), 32'h1);
        begin
            int stale;
            stale = 0;
            for (int i = 0; i < 12; i++) begin
                tick();
                if (o_valid === 1'b1 || o_data !== 32'h0) stale++;
            end
            chk("midrst_no_stale", 32'(stale), 32'h0);
        end
        prev_result = 32'h0;

        for (int i = 0; i < 1000; i++) begin
            logic [31:0] d;
            logic [4:0]  s;
            logic [1:0]  m;
            d = $urandom;
            s = 5'($urandom_range(0, 31));
            m = 2'($urandom_range(0, 3));
            if ((i % 7) == 0) d[31] = 1'b1;
            do_op(d, s, m, ref_shift(d, s, m), ref_lat(s), $urandom_range(0, 2),
                  $sformatf("rnd%0d_m%0d_s%0d", i, m, s));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
